// File: rtl/hk_input_pkg.sv
// rtl/hk_input_pkg.sv - HID keycodes and attack FSM state type shared by the keyboard input path
package hk_input_pkg;

  localparam logic [7:0] HID_KEY_A     = 8'h04;
  localparam logic [7:0] HID_KEY_D     = 8'h07;
  localparam logic [7:0] HID_KEY_J     = 8'h0D;
  localparam logic [7:0] HID_KEY_SPACE = 8'h2C;
  localparam logic [7:0] HID_KEY_NONE  = 8'h00;

  typedef enum logic [1:0] {
    ATK_IDLE   = 2'd0,
    ATK_ACTIVE = 2'd1,
    ATK_COOL   = 2'd2
  } atk_state_t;

endpackage

// File: rtl/frame_tick_sync.sv
// rtl/frame_tick_sync.sv - brings VGA_VS into the Clk domain and emits a one-Clk tick on its rising edge
module frame_tick_sync (
  input  logic Clk,
  input  logic Reset_n,
  input  logic async_in,
  output logic tick
);

  logic sync_q1, sync_q2;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= async_in;
      sync_q2 <= sync_q1;
    end
  end

  assign tick = sync_q1 & ~sync_q2;

endmodule

// File: rtl/keycode_action_decoder.sv
// rtl/keycode_action_decoder.sv - frame-aligned Player1 move/jump/attack commands from the HID keycode
// Optional build macro ATTACK_AUTOREPEAT_EN: a held attack key re-triggers attacks from IDLE.
module keycode_action_decoder
  import hk_input_pkg::*;
#(
  parameter logic [7:0] KEY_LEFT      = HID_KEY_A,
  parameter logic [7:0] KEY_RIGHT     = HID_KEY_D,
  parameter logic [7:0] KEY_JUMP      = HID_KEY_SPACE,
  parameter logic [7:0] KEY_ATTACK    = HID_KEY_J,
  parameter int         ATK_ACTIVE_FR = 6,
  parameter int         ATK_COOL_FR   = 10
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  output logic       move_left,
  output logic       move_right,
  output logic       facing_left,
  output logic       jump_req,
  output logic       attack_active,
  output logic       attack_start,
  output logic [1:0] atk_state
);

  localparam logic [5:0] ACT_LOAD  = 6'(ATK_ACTIVE_FR - 1);
  localparam logic [5:0] COOL_LOAD = 6'(ATK_COOL_FR - 1);

  logic tick;

  frame_tick_sync u_sync (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .async_in (frame_clk),
    .tick     (tick)
  );

  logic [7:0] key_now_q, key_now_d;
  logic       move_left_q, move_left_d;
  logic       move_right_q, move_right_d;
  logic       facing_left_q, facing_left_d;
  logic       jump_req_q, jump_req_d;
  logic       attack_start_q, attack_start_d;
  logic       buf_q, buf_d;
  logic [5:0] cnt_q, cnt_d;
  atk_state_t state_q, state_d;
  logic       start_atk;

  // key_now_q still holds the previous frame's sample here, so it acts as key_prev for press detection
`ifdef ATTACK_AUTOREPEAT_EN
  assign start_atk = (keycode == KEY_ATTACK) | buf_q;
`else
  logic press_atk;
  assign press_atk = (keycode == KEY_ATTACK) && (key_now_q != KEY_ATTACK);
  assign start_atk = press_atk | buf_q;
`endif

  always_comb begin
    key_now_d      = key_now_q;
    move_left_d    = move_left_q;
    move_right_d   = move_right_q;
    facing_left_d  = facing_left_q;
    jump_req_d     = jump_req_q;
    attack_start_d = attack_start_q;
    buf_d          = buf_q;
    cnt_d          = cnt_q;
    state_d        = state_q;
    if (tick) begin
      key_now_d      = keycode;
      move_left_d    = (keycode == KEY_LEFT);
      move_right_d   = (keycode == KEY_RIGHT);
      if (move_left_d)       facing_left_d = 1'b1;
      else if (move_right_d) facing_left_d = 1'b0;
      jump_req_d     = (keycode == KEY_JUMP) && (key_now_q != KEY_JUMP);
      attack_start_d = 1'b0;
      case (state_q)
        ATK_IDLE: begin
          if (start_atk) begin
            state_d        = ATK_ACTIVE;
            cnt_d          = ACT_LOAD;
            attack_start_d = 1'b1;
            buf_d          = 1'b0;
          end
        end
        ATK_ACTIVE: begin
          if (cnt_q == 6'd0) begin
            if (ATK_COOL_FR == 0) begin
              state_d = ATK_IDLE;
            end else begin
              state_d = ATK_COOL;
              cnt_d   = COOL_LOAD;
            end
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
`ifndef ATTACK_AUTOREPEAT_EN
          if (press_atk) buf_d = 1'b1;
`endif
        end
        ATK_COOL: begin
          if (cnt_q == 6'd0) state_d = ATK_IDLE;
          else               cnt_d   = cnt_q - 6'd1;
`ifndef ATTACK_AUTOREPEAT_EN
          if (press_atk) buf_d = 1'b1;
`endif
        end
        default: begin
          state_d = ATK_IDLE;
          cnt_d   = 6'd0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      key_now_q      <= 8'h00;
      move_left_q    <= 1'b0;
      move_right_q   <= 1'b0;
      facing_left_q  <= 1'b0;
      jump_req_q     <= 1'b0;
      attack_start_q <= 1'b0;
      buf_q          <= 1'b0;
      cnt_q          <= 6'd0;
      state_q        <= ATK_IDLE;
    end else begin
      key_now_q      <= key_now_d;
      move_left_q    <= move_left_d;
      move_right_q   <= move_right_d;
      facing_left_q  <= facing_left_d;
      jump_req_q     <= jump_req_d;
      attack_start_q <= attack_start_d;
      buf_q          <= buf_d;
      cnt_q          <= cnt_d;
      state_q        <= state_d;
    end
  end

  assign move_left     = move_left_q;
  assign move_right    = move_right_q;
  assign facing_left   = facing_left_q;
  assign jump_req      = jump_req_q;
  assign attack_start  = attack_start_q;
  assign attack_active = (state_q == ATK_ACTIVE);
  assign atk_state     = state_q;

endmodule
